// File: rtl/chunked_cla_adder.sv
// Multi-cycle adder: one CHUNK-bit carry chain reused over WIDTH/CHUNK cycles.
// Chunks are processed LSB first; the carry between chunks lives in carry_q.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding chunk idx_q this cycle, carry from previous chunk in carry_q
// DONE  | result held on out_sum/out_cout until out_ready
`timescale 1ns/1ps

module chunked_cla_adder #(
    parameter int WIDTH = 20,
    parameter int CHUNK = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_cla_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic [CHUNK-1:0]  g, p, sum_k;
    logic [CHUNK:0]    c;

    // Select the active chunk and run the generate/propagate ripple across it.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
        g    = a_chunk & b_chunk;
        p    = a_chunk ^ b_chunk;
        c    = '0;
        c[0] = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum_k = p ^ c[CHUNK-1:0];
    end

    // Next-state: operand capture, per-chunk result write-back and handshakes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        sum_d[k*CHUNK +: CHUNK] = sum_k;
                    end
                end
                carry_d = c[CHUNK];
                if (idx_q == LAST_IDX) begin
                    cout_d  = c[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule
